// File: rtl/alu_pkg.sv
// Shared opcode, flag and helper definitions for the pipelined ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SHL1 = 3'b101,
    ALU_MIN  = 3'b110,
    ALU_MAX  = 3'b111
  } alu_op_e;

  localparam int ALU_OP_W = 3;

  typedef struct packed {
    logic parity;
    logic overflow;
    logic greater;
    logic is_eq;
    logic less;
  } alu_flags_t;

  localparam alu_flags_t ALU_FLAGS_CLR = '{default: 1'b0};

endpackage

// File: rtl/alu_pipe_if.sv
// Operand-issue and result handshake bundle between the issue logic,
// the ALU pipeline and the writeback/flag consumers.
interface alu_pipe_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  alu_op_e          op;
  logic             oe;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             parity;
  logic             overflow;
  logic             greater;
  logic             is_eq;
  logic             less;

  // Environment side: issues operands and consumes results.
  modport master (
    output in_valid, a, b, op, oe, out_ready,
    input  in_ready, out_valid, y, parity, overflow, greater, is_eq, less
  );

  // ALU side.
  modport slave (
    input  in_valid, a, b, op, oe, out_ready,
    output in_ready, out_valid, y, parity, overflow, greater, is_eq, less
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU datapath: result, overflow, saturation, compare flags
// and output-enable gating for one operand set.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0,
  parameter int SAT    = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  input  logic             oe,
  output logic [WIDTH-1:0] y,
  output alu_flags_t       flags
);

  // Clamp limits of the active number range.
  localparam logic [WIDTH-1:0] RNG_MAX = (SIGNED != 0) ? {1'b0, {(WIDTH-1){1'b1}}} : {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] RNG_MIN = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : {WIDTH{1'b0}};

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             a_lt;
  logic             a_eq;
  logic             ovf;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] sat_val;
  logic [WIDTH-1:0] y_gated;

  // Compute the raw result, its overflow and the saturated replacement.
  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    a_eq    = (a == b);
    a_lt    = (SIGNED != 0) ? ($signed(a) < $signed(b)) : (a < b);
    res     = '0;
    ovf     = 1'b0;
    // Signed overflow direction always follows the sign of a.
    sat_val = a[WIDTH-1] ? RNG_MIN : RNG_MAX;

    case (op)
      ALU_ADD: begin
        res = sum[WIDTH-1:0];
        if (SIGNED != 0) begin
          ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end else begin
          ovf     = sum[WIDTH];
          sat_val = RNG_MAX;
        end
      end
      ALU_SUB: begin
        res = diff[WIDTH-1:0];
        if (SIGNED != 0) begin
          ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        end else begin
          ovf     = diff[WIDTH];
          sat_val = RNG_MIN;
        end
      end
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_XOR: res = a ^ b;
      ALU_SHL1: begin
        res = {a[WIDTH-2:0], 1'b0};
        if (SIGNED != 0) begin
          ovf = a[WIDTH-1] ^ a[WIDTH-2];
        end else begin
          ovf     = a[WIDTH-1];
          sat_val = RNG_MAX;
        end
      end
      ALU_MIN: res = a_lt ? a : b;
      ALU_MAX: res = a_lt ? b : a;
      default: res = '0;
    endcase

    if ((SAT != 0) && ovf) begin
      res = sat_val;
    end
  end

  // Output enable gates only the result and its parity.
  always_comb begin
    y_gated        = oe ? res : '0;
    y              = y_gated;
    flags.parity   = ^y_gated;
    flags.overflow = ovf;
    flags.greater  = !a_lt && !a_eq;
    flags.is_eq    = a_eq;
    flags.less     = a_lt;
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready flow control and a saturating
// overflow-event counter.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0,
  parameter int SAT    = 0,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_pipe_if.slave        bus,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_count
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  alu_op_e          s1_op;
  logic             s1_oe;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_y;
  alu_flags_t       s2_flags;

  logic             s2_adv;
  logic             s1_adv;
  logic [WIDTH-1:0] core_y;
  alu_flags_t       core_flags;
  logic             ovf_event;

  // Stage advance conditions; in_ready is the only path combinational from out_ready.
  always_comb begin
    s2_adv       = !s2_valid || bus.out_ready;
    s1_adv       = !s1_valid || s2_adv;
    bus.in_ready = s1_adv;
    ovf_event    = s2_valid && bus.out_ready && s2_flags.overflow;
  end

  alu_core #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED),
    .SAT    (SAT)
  ) u_core (
    .a     (s1_a),
    .b     (s1_b),
    .op    (s1_op),
    .oe    (s1_oe),
    .y     (core_y),
    .flags (core_flags)
  );

  // Stage 1: capture an operand beat whenever the stage can move.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= ALU_ADD;
      s1_oe    <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a  <= bus.a;
        s1_b  <= bus.b;
        s1_op <= bus.op;
        s1_oe <= bus.oe;
      end
    end
  end

  // Stage 2: register result and flags; hold while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_y     <= '0;
      s2_flags <= ALU_FLAGS_CLR;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_y     <= core_y;
        s2_flags <= core_flags;
      end
    end
  end

  // Count transferred overflow beats; clear wins over a coincident event.
  always_ff @(posedge clk) begin
    if (rst || ovf_clr) begin
      ovf_count <= '0;
    end else if (ovf_event && (ovf_count != {CNT_W{1'b1}})) begin
      ovf_count <= ovf_count + 1'b1;
    end
  end

  // Drive the result side of the bundle from stage 2.
  always_comb begin
    bus.out_valid = s2_valid;
    bus.y         = s2_y;
    bus.parity    = s2_flags.parity;
    bus.overflow  = s2_flags.overflow;
    bus.greater   = s2_flags.greater;
    bus.is_eq     = s2_flags.is_eq;
    bus.less      = s2_flags.less;
  end

endmodule
